// File: rtl/sprite_scheduler.sv
// ----------------------------------------------------------------------------
// sprite_scheduler
//
// Holds the active and staged top-left positions of every sprite (index 0 is
// Pacman, the rest are ghosts). Game logic stages new positions through a
// valid/ready handshake. A frame_start pulse walks the sprites one per cycle
// and copies each staged position into the active set, so the picture never
// tears mid-frame. Every pixel is hit-tested against all active 16x16 sprites.
// The lowest-index covering sprite wins, and its index, relative coordinates
// and sprite-ROM address are registered one cycle later.
//
// Parameters:
//   NUM_SPRITES  number of sprites (index 0 has the highest priority)
//   IDX_W        index width, 2**IDX_W >= NUM_SPRITES
//
// Ports:
//   VGA_CLK       pixel clock; all state changes on its rising edge
//   HRESETn       asynchronous active-low reset
//   frame_start   one-cycle pulse at the start of vertical blank
//   screen_x/y    current pixel coordinates (11 bit)
//   upd_valid     position update request
//   upd_ready     high while updates can be accepted (idle, not committing)
//   upd_idx       sprite to update; out-of-range indices are accepted and dropped
//   upd_x/upd_y   new top-left position (10 bit)
//   pending       per sprite: staged position waiting for the next commit
//   hit           some sprite covers the pixel (registered)
//   hit_idx       winning sprite; holds its value when there is no hit
//   rel_x/rel_y   pixel offset inside the winning sprite; held when no hit
//   rom_addr      {hit_idx, rel_y, rel_x} for the shared sprite ROM
//   collide       OR of collide_mask
//   collide_mask  bit i-1: Pacman and ghost i covered the same pixel since the
//                 last frame_start (sticky)
//
// Build option:
//   SPRITE_SCHED_COLLIDE_EN  when defined, builds the Pacman/ghost collision
//                            detector. When undefined, collide and
//                            collide_mask are tied to 0.
// ----------------------------------------------------------------------------
module sprite_scheduler #(
    parameter int NUM_SPRITES = 5,
    parameter int IDX_W       = 3
) (
    input  logic                   VGA_CLK,
    input  logic                   HRESETn,
    input  logic                   frame_start,
    input  logic [10:0]            screen_x,
    input  logic [10:0]            screen_y,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [IDX_W-1:0]       upd_idx,
    input  logic [9:0]             upd_x,
    input  logic [9:0]             upd_y,
    output logic [NUM_SPRITES-1:0] pending,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [3:0]             rel_x,
    output logic [3:0]             rel_y,
    output logic [IDX_W+7:0]       rom_addr,
    output logic                   collide,
    output logic [NUM_SPRITES-2:0] collide_mask
);

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(NUM_SPRITES - 1);
    localparam logic [IDX_W:0]   NUM_SPR_W = (IDX_W + 1)'(NUM_SPRITES);
    localparam logic [9:0]       OFFSCREEN = 10'h3FF;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic             commit_en;
    logic             upd_fire;
    logic             idx_ok;

    logic [9:0] act_x [NUM_SPRITES];
    logic [9:0] act_y [NUM_SPRITES];
    logic [9:0] stg_x [NUM_SPRITES];
    logic [9:0] stg_y [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] hit_vec;
    logic [IDX_W-1:0]       win_idx;
    logic [3:0]             win_rx;
    logic [3:0]             win_ry;

    // ------------------------------------------------------------------
    // Commit sequencer
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge VGA_CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no
    // path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        upd_ready  = 1'b0;
        commit_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                upd_ready = 1'b1;
                if (frame_start) begin
                    state_next = ST_COMMIT;
                    ptr_next   = '0;
                end
            end
            ST_COMMIT: begin
                // frame_start is deliberately ignored here; a commit already
                // in flight must finish walking every sprite.
                commit_en = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + IDX_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    assign upd_fire = upd_valid && upd_ready;
    assign idx_ok   = {1'b0, upd_idx} < NUM_SPR_W;

    // ------------------------------------------------------------------
    // Position storage. Staging only happens in IDLE and copying only in
    // COMMIT, so the two never collide on the same sprite in one cycle.
    // ------------------------------------------------------------------
    // NOTE: the position arrays are reset element by element because the
    // off-screen reset value is what keeps stale sprites from drawing; they
    // are flops, not a RAM macro, so resetting them is legal and cheap.
    always_ff @(posedge VGA_CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_x[i] <= OFFSCREEN;
                act_y[i] <= OFFSCREEN;
                stg_x[i] <= '0;
                stg_y[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (upd_fire && idx_ok && (upd_idx == IDX_W'(i))) begin
                    stg_x[i]   <= upd_x;
                    stg_y[i]   <= upd_y;
                    pending[i] <= 1'b1;
                end else if (commit_en && (ptr == IDX_W'(i)) && pending[i]) begin
                    act_x[i]   <= stg_x[i];
                    act_y[i]   <= stg_y[i];
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit test. The compare is done in 11 bits so a sprite near the right
    // or bottom edge extends past 1023 instead of wrapping to column 0.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [10:0] x_lo;
        logic [10:0] y_lo;
        assign x_lo = {1'b0, act_x[g]};
        assign y_lo = {1'b0, act_y[g]};
        assign hit_vec[g] = (screen_x >= x_lo) && (screen_x <= x_lo + 11'd15) &&
                            (screen_y >= y_lo) && (screen_y <= y_lo + 11'd15);
    end

    // Priority pick: scan from the highest index down so the lowest
    // covering index is the last to write. The low nibble of a difference
    // depends only on the low nibbles of its operands, which is all the
    // 16x16 offset needs.
    always_comb begin
        win_idx = '0;
        win_rx  = '0;
        win_ry  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_idx = IDX_W'(i);
                win_rx  = screen_x[3:0] - act_x[i][3:0];
                win_ry  = screen_y[3:0] - act_y[i][3:0];
            end
        end
    end

    // Pixel outputs: one cycle of latency; winner fields hold on a miss so
    // the ROM address stays stable through background pixels.
    always_ff @(posedge VGA_CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hit     <= 1'b0;
            hit_idx <= '0;
            rel_x   <= '0;
            rel_y   <= '0;
        end else begin
            hit <= |hit_vec;
            if (|hit_vec) begin
                hit_idx <= win_idx;
                rel_x   <= win_rx;
                rel_y   <= win_ry;
            end
        end
    end

    assign rom_addr = {hit_idx, rel_y, rel_x};

    // ------------------------------------------------------------------
    // Pacman/ghost collision flags
    // ------------------------------------------------------------------
`ifdef SPRITE_SCHED_COLLIDE_EN
    logic [NUM_SPRITES-2:0] coll_set;

    assign coll_set = hit_vec[0] ? hit_vec[NUM_SPRITES-1:1] : '0;

    // A new collision on the frame_start pixel survives the clear.
    always_ff @(posedge VGA_CLK or negedge HRESETn) begin
        if (!HRESETn) begin
            collide_mask <= '0;
        end else begin
            collide_mask <= (frame_start ? '0 : collide_mask) | coll_set;
        end
    end

    assign collide = |collide_mask;
`else
    assign collide      = 1'b0;
    assign collide_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sprite_scheduler
//
// Self-checking bench for sprite_scheduler. A behavioural model keeps the
// active/staged positions as plain integers, applies a whole commit at once
// when the hardware finishes walking the sprites, and finds the pixel winner
// by scanning sprites in priority order with integer arithmetic. The screen
// is parked at an uncovered coordinate between pixel probes, so the hold and
// sticky-collision state only changes where the model expects it.
// ----------------------------------------------------------------------------
module tb_sprite_scheduler;

    localparam int NS   = 5;
    localparam int IW   = 3;
    localparam int PARK = 2047;

    logic           VGA_CLK = 1'b0;
    logic           HRESETn = 1'b0;
    logic           frame_start = 1'b0;
    logic [10:0]    screen_x = 11'(PARK);
    logic [10:0]    screen_y = 11'(PARK);
    logic           upd_valid = 1'b0;
    logic           upd_ready;
    logic [IW-1:0]  upd_idx = '0;
    logic [9:0]     upd_x = '0;
    logic [9:0]     upd_y = '0;
    logic [NS-1:0]  pending;
    logic           hit;
    logic [IW-1:0]  hit_idx;
    logic [3:0]     rel_x;
    logic [3:0]     rel_y;
    logic [IW+7:0]  rom_addr;
    logic           collide;
    logic [NS-2:0]  collide_mask;

    sprite_scheduler #(
        .NUM_SPRITES (NS),
        .IDX_W       (IW)
    ) dut (
        .VGA_CLK      (VGA_CLK),
        .HRESETn      (HRESETn),
        .frame_start  (frame_start),
        .screen_x     (screen_x),
        .screen_y     (screen_y),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_x        (upd_x),
        .upd_y        (upd_y),
        .pending      (pending),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .rel_x        (rel_x),
        .rel_y        (rel_y),
        .rom_addr     (rom_addr),
        .collide      (collide),
        .collide_mask (collide_mask)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            m_ax [NS];
    int            m_ay [NS];
    int            m_sx [NS];
    int            m_sy [NS];
    logic [NS-1:0] m_pend;
    logic [IW-1:0] m_idx;
    logic [3:0]    m_rx;
    logic [3:0]    m_ry;
    logic [NS-2:0] m_mask;

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_ax[i] = 1023;
            m_ay[i] = 1023;
            m_sx[i] = 0;
            m_sy[i] = 0;
        end
        m_pend = '0;
        m_idx  = '0;
        m_rx   = '0;
        m_ry   = '0;
        m_mask = '0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < NS; i++) begin
            if (m_pend[i]) begin
                m_ax[i] = m_sx[i];
                m_ay[i] = m_sy[i];
            end
        end
        m_pend = '0;
        m_mask = '0;
    endtask

    function automatic bit covers(int i, int sx, int sy);
        return (sx >= m_ax[i]) && (sx <= m_ax[i] + 15) &&
               (sy >= m_ay[i]) && (sy <= m_ay[i] + 15);
    endfunction

    task automatic do_update(input int idx, input int x, input int y);
        upd_valid = 1'b1;
        upd_idx   = IW'(idx);
        upd_x     = 10'(x);
        upd_y     = 10'(y);
        checks++;
        if (upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL upd_ready_idle: got %b want 1", upd_ready);
        end
        tick();
        upd_valid = 1'b0;
        if (idx < NS) begin
            m_sx[idx]   = x;
            m_sy[idx]   = y;
            m_pend[idx] = 1'b1;
        end
        checks++;
        if (pending !== m_pend) begin
            failures++;
            $display("FAIL pending_after_update idx=%0d: got %b want %b", idx, pending, m_pend);
        end
    endtask

    task automatic do_frame();
        int low;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        low = 0;
        while (upd_ready === 1'b0 && low < 20) begin
            low++;
            tick();
        end
        checks++;
        if (low != NS) begin
            failures++;
            $display("FAIL commit_ready_low: got %0d cycles want %0d", low, NS);
        end
        model_commit();
        checks++;
        if (pending !== m_pend) begin
            failures++;
            $display("FAIL pending_after_commit: got %b want %b", pending, m_pend);
        end
    endtask

    task automatic check_pixel(input int sx, input int sy);
        logic          e_hit;
        logic [IW+7:0] e_rom;
        int            w;
        screen_x = 11'(sx);
        screen_y = 11'(sy);
        tick();
        screen_x = 11'(PARK);
        screen_y = 11'(PARK);
        w = -1;
        for (int i = 0; i < NS; i++) begin
            if (w < 0 && covers(i, sx, sy)) w = i;
        end
        e_hit = (w >= 0);
        if (e_hit) begin
            m_idx = IW'(w);
            m_rx  = 4'((sx - m_ax[w]) & 15);
            m_ry  = 4'((sy - m_ay[w]) & 15);
        end
`ifdef SPRITE_SCHED_COLLIDE_EN
        if (covers(0, sx, sy)) begin
            for (int i = 1; i < NS; i++) begin
                if (covers(i, sx, sy)) m_mask[i-1] = 1'b1;
            end
        end
`endif
        e_rom = {m_idx, m_ry, m_rx};
        checks++;
        if (hit !== e_hit) begin
            failures++;
            $display("FAIL pix_hit (%0d,%0d): got %b want %b", sx, sy, hit, e_hit);
        end
        checks++;
        if (hit_idx !== m_idx) begin
            failures++;
            $display("FAIL pix_idx (%0d,%0d): got %0d want %0d", sx, sy, hit_idx, m_idx);
        end
        checks++;
        if (rel_x !== m_rx || rel_y !== m_ry) begin
            failures++;
            $display("FAIL pix_rel (%0d,%0d): got %0d,%0d want %0d,%0d", sx, sy, rel_x, rel_y, m_rx, m_ry);
        end
        checks++;
        if (rom_addr !== e_rom) begin
            failures++;
            $display("FAIL pix_rom (%0d,%0d): got %h want %h", sx, sy, rom_addr, e_rom);
        end
        checks++;
        if (collide_mask !== m_mask || collide !== (|m_mask)) begin
            failures++;
            $display("FAIL pix_collide (%0d,%0d): got %b/%b want %b/%b", sx, sy, collide, collide_mask, |m_mask, m_mask);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (upd_ready !== 1'b1 || pending !== '0) begin
            failures++;
            $display("FAIL %s_ctrl: got ready=%b pending=%b want 1/0", tag, upd_ready, pending);
        end
        checks++;
        if (hit !== 1'b0 || hit_idx !== '0 || rel_x !== '0 || rel_y !== '0 || rom_addr !== '0) begin
            failures++;
            $display("FAIL %s_pix: got hit=%b idx=%0d rel=%0d,%0d rom=%h want all 0", tag, hit, hit_idx, rel_x, rel_y, rom_addr);
        end
        checks++;
        if (collide !== 1'b0 || collide_mask !== '0) begin
            failures++;
            $display("FAIL %s_collide: got %b/%b want 0/0", tag, collide, collide_mask);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        model_reset();
        tick();
        tick();
        check_idle_outputs("reset");
        HRESETn = 1'b1;
        tick();
        check_idle_outputs("post_reset");
    endtask

    task automatic test_empty_sweep();
        for (int i = 0; i < 640; i++) begin
            screen_x = 11'(i);
            screen_y = 11'd0;
            tick();
            checks++;
            if (hit !== 1'b0) begin
                failures++;
                $display("FAIL sweep_hit x=%0d: got %b want 0", i, hit);
            end
        end
        screen_x = 11'(PARK);
        screen_y = 11'(PARK);
    endtask

    task automatic test_reset_mid_commit();
        do_update(1, 500, 500);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("mid_commit_reset");
        tick();
        HRESETn = 1'b1;
        tick();
        check_pixel(505, 505);
        do_frame();
        check_pixel(505, 505);
    endtask

    task automatic test_commit_timing();
        logic [NS-1:0] e_pend;
        do_update(2, 100, 50);
        frame_start = 1'b1;
        tick();                                  // edge E samples frame_start
        frame_start = 1'b0;
        for (int k = 1; k <= NS + 1; k++) begin
            checks++;
            if (upd_ready !== 1'b0) begin
                failures++;
                $display("FAIL commit_ready_e%0d: got %b want 0", k - 1, upd_ready);
            end
            if (k == 3) begin
                screen_x = 11'd107;
                screen_y = 11'd61;
            end
            tick();                              // edge E+k
            e_pend = (k >= 3) ? '0 : NS'(5'b00100);
            checks++;
            if (pending !== e_pend) begin
                failures++;
                $display("FAIL commit_pending_e%0d: got %b want %b", k, pending, e_pend);
            end
            if (k == 3) begin
                // pixel sampled at the copy edge still sees the old position
                checks++;
                if (hit !== 1'b0) begin
                    failures++;
                    $display("FAIL commit_visible_e3: got %b want 0", hit);
                end
            end
            if (k == 4) begin
                checks++;
                if (hit !== 1'b1 || hit_idx !== 3'd2) begin
                    failures++;
                    $display("FAIL commit_visible_e4: got %b/%0d want 1/2", hit, hit_idx);
                end
                screen_x = 11'(PARK);
                screen_y = 11'(PARK);
            end
            if (k == NS) break;
        end
        checks++;
        if (upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL commit_ready_end: got %b want 1", upd_ready);
        end
        model_commit();
        m_idx = 3'd2;
        m_rx  = 4'd7;
        m_ry  = 4'd11;
        check_pixel(107, 61);
        checks++;
        if (rom_addr !== {3'd2, 4'd11, 4'd7}) begin
            failures++;
            $display("FAIL commit_rom_const: got %h want %h", rom_addr, {3'd2, 4'd11, 4'd7});
        end
    endtask

    task automatic test_priority_collide();
        do_update(0, 200, 200);
        do_update(3, 200, 200);
        do_frame();
        check_pixel(205, 205);
        checks++;
        if (hit_idx !== 3'd0) begin
            failures++;
            $display("FAIL prio_idx: got %0d want 0", hit_idx);
        end
`ifdef SPRITE_SCHED_COLLIDE_EN
        checks++;
        if (collide_mask !== 4'b0100 || collide !== 1'b1) begin
            failures++;
            $display("FAIL collide_set: got %b/%b want 0100/1", collide_mask, collide);
        end
`endif
        check_pixel(PARK, PARK);                 // sticky: still set with no hit
        do_frame();
        checks++;
        if (collide_mask !== '0 || collide !== 1'b0) begin
            failures++;
            $display("FAIL collide_clear: got %b/%b want 0/0", collide_mask, collide);
        end
        check_pixel(PARK, PARK);
    endtask

    task automatic test_last_write_wins();
        do_update(1, 10, 10);
        do_update(1, 20, 20);
        do_frame();
        check_pixel(20, 20);
        check_pixel(10, 10);
    endtask

    task automatic test_frame_in_update_cycle();
        int low;
        checks++;
        if (upd_ready !== 1'b1) begin
            failures++;
            $display("FAIL fs_upd_ready: got %b want 1", upd_ready);
        end
        upd_valid   = 1'b1;
        upd_idx     = 3'd4;
        upd_x       = 10'd300;
        upd_y       = 10'd300;
        frame_start = 1'b1;
        tick();
        upd_valid   = 1'b0;
        frame_start = 1'b0;
        m_sx[4] = 300;
        m_sy[4] = 300;
        m_pend[4] = 1'b1;
        low = 0;
        for (int k = 0; k < 12; k++) begin
            if (upd_ready === 1'b0) low++;
            frame_start = (k == 4);              // lands on the last commit cycle
            tick();
        end
        frame_start = 1'b0;
        checks++;
        if (low != NS) begin
            failures++;
            $display("FAIL fs_extra_commit: got %0d low cycles want %0d", low, NS);
        end
        model_commit();
        checks++;
        if (pending !== m_pend) begin
            failures++;
            $display("FAIL fs_pending: got %b want %b", pending, m_pend);
        end
        check_pixel(305, 305);
    endtask

    task automatic test_bad_index();
        do_update(1, 600, 600);
        do_update(7, 0, 0);
        do_update(5, 2, 2);
        do_frame();
        check_pixel(0, 0);
        check_pixel(3, 3);
        check_pixel(605, 605);
    endtask

    task automatic test_boundary();
        do_update(3, 1020, 1008);
        do_frame();
        check_pixel(1035, 1023);
        checks++;
        if (rel_x !== 4'd15 || rel_y !== 4'd15 || hit_idx !== 3'd3) begin
            failures++;
            $display("FAIL edge_far: got idx=%0d rel=%0d,%0d want 3,15,15", hit_idx, rel_x, rel_y);
        end
        check_pixel(1036, 1023);
        check_pixel(1035, 1024);
        check_pixel(1019, 1008);
        check_pixel(1020, 1008);
        check_pixel(4, 1010);                    // no wrap to the left edge
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int u = 0; u < n; u++) begin
                int idx, x, y;
                idx = int'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) begin
                    x = 400 + int'($urandom_range(0, 40));
                    y = 300 + int'($urandom_range(0, 40));
                end else begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end
                do_update(idx, x, y);
            end
            do_frame();
            for (int p = 0; p < 6; p++) begin
                int j, sx, sy;
                j  = int'($urandom_range(0, NS - 1));
                sx = m_ax[j] + int'($urandom_range(0, 19)) - 2;
                sy = m_ay[j] + int'($urandom_range(0, 19)) - 2;
                if (sx < 0) sx = 0;
                if (sy < 0) sy = 0;
                check_pixel(sx, sy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_sweep();
        test_reset_mid_commit();
        test_commit_timing();
        test_priority_collide();
        test_last_write_wins();
        test_frame_in_update_cycle();
        test_bad_index();
        test_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
